// File: rtl/pc_pkg.sv
// pc_pkg: shared defaults and next-PC select encoding
// for the program-counter sequencer.
package pc_pkg;

  localparam int unsigned DEF_WIDTH        = 32;
  localparam int unsigned DEF_STEP         = 4;
  localparam int unsigned DEF_RESET_VECTOR = 0;
  localparam int unsigned DEF_RAS_DEPTH    = 4;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_REDIR,
    SEL_CALL,
    SEL_RET
  } sel_e;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full
// overwrites the oldest entry so the newest DEPTH survive.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    tp;
  logic [CW-1:0]    cnt;

  assign tp    = wp - PW'(1);
  assign top   = mem[tp];
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(RAS_DEPTH));
  assign ovf   = push && full;
  assign unf   = pop && empty;

  // write pointer and occupancy; count saturates at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      cnt <= '0;
    end else if (push) begin
      wp <= wp + PW'(1);
      if (!full) cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      wp  <= tp;
      cnt <= cnt - CW'(1);
    end
  end

  // entry storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register with step, redirect, and
// call/return through a hardware return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     WIDTH        = DEF_WIDTH,
  parameter int unsigned     STEP         = DEF_STEP,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter int unsigned     RAS_DEPTH    = DEF_RAS_DEPTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             REDIRECT,
  input  logic             CALL,
  input  logic             RET,
  input  logic [WIDTH-1:0] TARGET,
  input  logic             ERR_CLR,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_NEXT,
  output logic             RAS_EMPTY,
  output logic             RAS_FULL,
  output logic             RAS_ERR
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] pc_nx;
  sel_e             sel;
  logic             push;
  logic             pop;
  logic             ovf;
  logic             unf;
  logic             err_q;

  assign pc_plus = pc_q + WIDTH'(STEP);

  // RET over CALL over REDIRECT over sequential
  always_comb begin
    sel = SEL_SEQ;
    priority case (1'b1)
      RET:      sel = SEL_RET;
      CALL:     sel = SEL_CALL;
      REDIRECT: sel = SEL_REDIR;
      default:  sel = SEL_SEQ;
    endcase
  end

  assign push = EN && (sel == SEL_CALL);
  assign pop  = EN && (sel == SEL_RET);

  // next-PC mux; an empty-stack return falls back to TARGET
  always_comb begin
    pc_nx = pc_q;
    if (EN) begin
      unique case (sel)
        SEL_SEQ:   pc_nx = pc_plus;
        SEL_REDIR: pc_nx = TARGET;
        SEL_CALL:  pc_nx = TARGET;
        SEL_RET:   pc_nx = RAS_EMPTY ? TARGET : ras_top;
        default:   pc_nx = pc_q;
      endcase
    end
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (pc_plus),
    .top   (ras_top),
    .empty (RAS_EMPTY),
    .full  (RAS_FULL),
    .ovf   (ovf),
    .unf   (unf)
  );

  // architectural PC register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pc_q <= RESET_VECTOR;
    else     pc_q <= pc_nx;
  end

  // sticky stack error; a new fault wins over a clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            err_q <= 1'b0;
    else if (ovf || unf) err_q <= 1'b1;
    else if (ERR_CLR)   err_q <= 1'b0;
  end

  assign PC      = pc_q;
  assign PC_NEXT = pc_nx;
  assign RAS_ERR = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with a queued scoreboard
// checked by a monitor at each clock edge.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        rst_b;
  logic        en;
  logic        redirect;
  logic        call;
  logic        ret;
  logic [31:0] target;
  logic        err_clr;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;
  logic [31:0] b_pc;
  logic [31:0] b_next;
  logic        b_empty;
  logic        b_full;
  logic        b_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] nxt;
    logic [31:0] pc;
    logic        emp;
    logic        ful;
    logic        err;
  } exp_t;

  exp_t q[$];

  pc_sequencer #(
    .WIDTH(32), .STEP(4), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)
  ) dut (
    .CLK(clk), .RST(rst), .EN(en), .REDIRECT(redirect),
    .CALL(call), .RET(ret), .TARGET(target), .ERR_CLR(err_clr),
    .PC(pc), .PC_NEXT(pc_next), .RAS_EMPTY(ras_empty),
    .RAS_FULL(ras_full), .RAS_ERR(ras_err)
  );

  pc_sequencer #(
    .WIDTH(32), .STEP(4), .RESET_VECTOR(32'hFFFF_FFFC), .RAS_DEPTH(4)
  ) dut_b (
    .CLK(clk), .RST(rst_b), .EN(en), .REDIRECT(redirect),
    .CALL(call), .RET(ret), .TARGET(target), .ERR_CLR(err_clr),
    .PC(b_pc), .PC_NEXT(b_next), .RAS_EMPTY(b_empty),
    .RAS_FULL(b_full), .RAS_ERR(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: PC_NEXT just before the edge, registered state after
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({e.name, ".next"}, pc_next, e.nxt);
        #1;
        chk({e.name, ".pc"}, pc, e.pc);
        chk({e.name, ".empty"}, 32'(ras_empty), 32'(e.emp));
        chk({e.name, ".full"}, 32'(ras_full), 32'(e.ful));
        chk({e.name, ".err"}, 32'(ras_err), 32'(e.err));
      end
    end
  end

  task automatic cyc(input string nm, input logic e_n,
                     input logic rd, input logic cl, input logic rt,
                     input logic [31:0] tg, input logic clr,
                     input logic [31:0] xn, input logic [31:0] xp,
                     input logic xe, input logic xf, input logic xr);
    exp_t e;
    @(negedge clk);
    en = e_n; redirect = rd; call = cl; ret = rt;
    target = tg; err_clr = clr;
    e.name = nm; e.nxt = xn; e.pc = xp;
    e.emp = xe; e.ful = xf; e.err = xr;
    q.push_back(e);
  endtask

  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d items left, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    en = 0; redirect = 0; call = 0; ret = 0;
    target = 0; err_clr = 0;
    #12;
    chk("rst.pc", pc, 32'h0);
    chk("rst.empty", 32'(ras_empty), 32'd1);
    chk("rst.full", 32'(ras_full), 32'd0);
    chk("rst.err", 32'(ras_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //   name      en rd cl rt target        clr next           pc             e  f  r
    cyc("seq1",    1, 0, 0, 0, 32'h0,        0, 32'h4,         32'h4,         1, 0, 0);
    cyc("seq2",    1, 0, 0, 0, 32'h0,        0, 32'h8,         32'h8,         1, 0, 0);
    cyc("stall1",  0, 0, 1, 0, 32'h100,      0, 32'h8,         32'h8,         1, 0, 0);
    cyc("stall2",  0, 0, 1, 0, 32'h100,      0, 32'h8,         32'h8,         1, 0, 0);
    cyc("seq3",    1, 0, 0, 0, 32'h0,        0, 32'hC,         32'hC,         1, 0, 0);
    cyc("seq4",    1, 0, 0, 0, 32'h0,        0, 32'h10,        32'h10,        1, 0, 0);
    cyc("call0",   1, 0, 1, 0, 32'h100,      0, 32'h100,       32'h100,       0, 0, 0);
    cyc("ret0",    1, 0, 0, 1, 32'h0,        0, 32'h14,        32'h14,        1, 0, 0);
    cyc("redir0",  1, 1, 0, 0, 32'h0,        0, 32'h0,         32'h0,         1, 0, 0);
    cyc("callA",   1, 0, 1, 0, 32'h100,      0, 32'h100,       32'h100,       0, 0, 0);
    cyc("callB",   1, 0, 1, 0, 32'h200,      0, 32'h200,       32'h200,       0, 0, 0);
    cyc("callC",   1, 0, 1, 0, 32'h300,      0, 32'h300,       32'h300,       0, 0, 0);
    cyc("callD",   1, 0, 1, 0, 32'h400,      0, 32'h400,       32'h400,       0, 1, 0);
    cyc("callOvf", 1, 0, 1, 0, 32'h500,      0, 32'h500,       32'h500,       0, 1, 1);
    cyc("retA",    1, 0, 0, 1, 32'h0,        0, 32'h404,       32'h404,       0, 0, 1);
    cyc("retB",    1, 0, 0, 1, 32'h0,        0, 32'h304,       32'h304,       0, 0, 1);
    cyc("retC",    1, 0, 0, 1, 32'h0,        0, 32'h204,       32'h204,       0, 0, 1);
    cyc("retD",    1, 0, 0, 1, 32'h0,        0, 32'h104,       32'h104,       1, 0, 1);
    cyc("retUnf",  1, 0, 0, 1, 32'h800,      0, 32'h800,       32'h800,       1, 0, 1);
    cyc("clrStall",0, 0, 0, 0, 32'h0,        1, 32'h800,       32'h800,       1, 0, 0);
    cyc("setWins", 1, 0, 0, 1, 32'h40,       1, 32'h40,        32'h40,        1, 0, 1);
    cyc("clrSeq",  1, 0, 0, 0, 32'h0,        1, 32'h44,        32'h44,        1, 0, 0);
    cyc("redir40", 1, 1, 0, 0, 32'h40,       0, 32'h40,        32'h40,        1, 0, 0);
    cyc("call44",  1, 0, 1, 0, 32'h200,      0, 32'h200,       32'h200,       0, 0, 0);
    cyc("allCmd",  1, 1, 1, 1, 32'h300,      0, 32'h44,        32'h44,        1, 0, 0);
    cyc("redirHi", 1, 1, 0, 0, 32'hFFFFFFFC, 0, 32'hFFFFFFFC,  32'hFFFFFFFC,  1, 0, 0);
    cyc("wrap",    1, 0, 0, 0, 32'h0,        0, 32'h0,         32'h0,         1, 0, 0);
    cyc("callR1",  1, 0, 1, 0, 32'h10,       0, 32'h10,        32'h10,        0, 0, 0);
    cyc("callR2",  1, 0, 1, 0, 32'h20,       0, 32'h20,        32'h20,        0, 0, 0);
    drain();

    @(negedge clk);
    en = 0; call = 0; redirect = 0; ret = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst.pc", pc, 32'h0);
    chk("arst.empty", 32'(ras_empty), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    cyc("postRst", 1, 0, 0, 1, 32'h60,       0, 32'h60,        32'h60,        1, 0, 1);
    drain();

    @(negedge clk);
    en = 1; call = 0; redirect = 0; ret = 0; err_clr = 0;
    chk("b.rst.pc", b_pc, 32'hFFFF_FFFC);
    rst_b = 1'b0;
    #1;
    chk("b.next", b_next, 32'h0);
    @(posedge clk);
    #1;
    chk("b.wrap.pc", b_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
